mc_ctrl_fsm: RTL and testbench

//  Parametrised multicycle MIPS control unit, successor to the fixed control unit in the cpu top.

---
 rtl/mc_ctrl_fsm_if.sv | 54 +++++
 rtl/mc_ctrl_fsm.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Purpose : bundles the instruction fields, memory handshake and datapath
//           strobes exchanged between the multicycle control FSM and the
//           datapath / memory side.
// Signals :
//   opcode, funct  IR fields (instr[31:26], instr[5:0])
//   mem_ready      memory completes the current access this cycle
//   mem_req        memory access requested
//   mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_write, pc_write,
//   branch, reg_write                          1-bit datapath strobes
//   alu_src_b[1:0], pc_src[1:0], alu_control[ALU_CTRL_W-1:0]
//   instr_done     one-cycle pulse on the last cycle of each instruction
//   illegal_op     sticky unsupported-instruction flag
//   bus_err        sticky memory-timeout flag
// Modports: master = control FSM, slave = datapath / memory side.
// -----------------------------------------------------------------------------
interface mc_ctrl_fsm_if #(
    parameter int ALU_CTRL_W = 3
);
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic                  mem_ready;
    logic                  mem_req;
    logic                  mem_to_reg;
    logic                  reg_dest;
    logic                  i_or_d;
    logic                  alu_src_a;
    logic                  ir_write;
    logic                  mem_write;
    logic                  pc_write;
    logic                  branch;
    logic                  reg_write;
    logic [1:0]            alu_src_b;
    logic [1:0]            pc_src;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  instr_done;
    logic                  illegal_op;
    logic                  bus_err;

    modport master (
        input  opcode, funct, mem_ready,
        output mem_req, mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_write,
               pc_write, branch, reg_write, alu_src_b, pc_src, alu_control, instr_done,
               illegal_op, bus_err
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  mem_req, mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_write,
               pc_write, branch, reg_write, alu_src_b, pc_src, alu_control, instr_done,
               illegal_op, bus_err
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Purpose : multicycle MIPS control unit. Moore-style FSM decoding opcode/funct
//           into datapath strobes, with a memory wait-state handshake, a bus
//           timeout, sticky trap flags and a per-instruction retire pulse.
// Ports   :
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   ctrl_bus  mc_ctrl_fsm_if.master (IR fields, mem handshake, strobes, flags)
// Parameters:
//   ALU_CTRL_W   width of alu_control (codes in [2:0], upper bits zero)
//   WAIT_TIMEOUT stall cycles tolerated before a bus trap; 0 disables timeout
//   CNT_W        wait-counter width, must hold WAIT_TIMEOUT
// Build option:
//   MC_ADDI_EN   when defined, addi (opcode 001000) is executed through the
//                ADDIEX/ADDIWB states; otherwise it is an illegal opcode.
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
    parameter int ALU_CTRL_W   = 3,
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master ctrl_bus
);

    localparam logic [3:0] S_RESET  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_TRAP   = 4'd11;
`ifdef MC_ADDI_EN
    localparam logic [3:0] S_ADDIEX = 4'd12;
    localparam logic [3:0] S_ADDIWB = 4'd13;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_illegal_op;
    logic             r_bus_err;

    logic             w_mem_ready;
    logic             w_funct_ok;
    logic [2:0]       w_funct_alu;
    logic             w_tmo_hit;
    logic             w_in_mem;
    logic             w_next_mem;
    logic             w_illegal_set;
    logic             w_bus_set;

    logic             w_mem_req;
    logic             w_mem_to_reg;
    logic             w_reg_dest;
    logic             w_i_or_d;
    logic             w_alu_src_a;
    logic             w_ir_write;
    logic             w_mem_write;
    logic             w_pc_write;
    logic             w_branch;
    logic             w_reg_write;
    logic [1:0]       w_alu_src_b;
    logic [1:0]       w_pc_src;
    logic [2:0]       w_alu;
    logic             w_instr_done;

    assign w_mem_ready = ctrl_bus.mem_ready;

    // R-type funct decode: legality and ALU code
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = ALU_ADD;
        case (ctrl_bus.funct)
            6'b100000: w_funct_alu = ALU_ADD;
            6'b100010: w_funct_alu = ALU_SUB;
            6'b100100: w_funct_alu = ALU_AND;
            6'b100101: w_funct_alu = ALU_OR;
            6'b101010: w_funct_alu = ALU_SLT;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    assign w_in_mem   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_next_mem = (w_next == S_FETCH) || (w_next == S_MEMRD) || (w_next == S_MEMWR);

    // Timeout fires on the last tolerated stall cycle; a same-cycle mem_ready still completes.
    assign w_tmo_hit = (WAIT_TIMEOUT != 0) && (r_cnt == CNT_W'(WAIT_TIMEOUT - 1)) && !w_mem_ready;

    always_comb begin
        w_next        = r_state;
        w_illegal_set = 1'b0;
        w_bus_set     = 1'b0;
        case (r_state)
            S_RESET: w_next = S_FETCH;
            S_FETCH: begin
                if (w_mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_tmo_hit) begin
                    w_next    = S_TRAP;
                    w_bus_set = 1'b1;
                end
            end
            S_DECODE: begin
                case (ctrl_bus.opcode)
                    6'b100011, 6'b101011: w_next = S_MEMADR;
                    6'b000000:            w_next = w_funct_ok ? S_EXEC : S_TRAP;
                    6'b000100:            w_next = S_BRANCH;
                    6'b000010:            w_next = S_JUMP;
`ifdef MC_ADDI_EN
                    6'b001000:            w_next = S_ADDIEX;
`endif
                    default:              w_next = S_TRAP;
                endcase
                w_illegal_set = (w_next == S_TRAP);
            end
            S_MEMADR: w_next = (ctrl_bus.opcode == 6'b101011) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (w_mem_ready) begin
                    w_next = S_MEMWB;
                end else if (w_tmo_hit) begin
                    w_next    = S_TRAP;
                    w_bus_set = 1'b1;
                end
            end
            S_MEMWR: begin
                if (w_mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_tmo_hit) begin
                    w_next    = S_TRAP;
                    w_bus_set = 1'b1;
                end
            end
            S_MEMWB:  w_next = S_FETCH;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
`endif
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_TRAP;
        endcase
    end

    // Stall counter restarts on entering a memory state and whenever an access completes.
    always_comb begin
        w_cnt_next = r_cnt;
        if ((w_next_mem && (w_next != r_state)) || w_mem_ready) begin
            w_cnt_next = '0;
        end else if (w_in_mem) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_RESET;
            r_cnt        <= '0;
            r_illegal_op <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_illegal_op <= r_illegal_op | w_illegal_set;
            r_bus_err    <= r_bus_err | w_bus_set;
        end
    end

    // Strobe decode; only FETCH write-enables and the MEMWR retire pulse look at mem_ready.
    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_dest   = 1'b0;
        w_i_or_d     = 1'b0;
        w_alu_src_a  = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_pc_src     = 2'b00;
        w_alu        = 3'b000;
        w_instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = 2'b01;
                w_alu       = ALU_ADD;
                w_ir_write  = w_mem_ready;
                w_pc_write  = w_mem_ready;
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                w_alu       = ALU_ADD;
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu       = ALU_ADD;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_i_or_d  = 1'b1;
            end
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_mem_req    = 1'b1;
                w_mem_write  = 1'b1;
                w_i_or_d     = 1'b1;
                w_instr_done = w_mem_ready;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu       = w_funct_alu;
            end
            S_ALUWB: begin
                w_reg_dest   = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu        = ALU_SUB;
                w_pc_src     = 2'b01;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
            end
            S_JUMP: begin
                w_pc_src     = 2'b10;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu       = ALU_ADD;
            end
            S_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign ctrl_bus.mem_req     = w_mem_req;
    assign ctrl_bus.mem_to_reg  = w_mem_to_reg;
    assign ctrl_bus.reg_dest    = w_reg_dest;
    assign ctrl_bus.i_or_d      = w_i_or_d;
    assign ctrl_bus.alu_src_a   = w_alu_src_a;
    assign ctrl_bus.ir_write    = w_ir_write;
    assign ctrl_bus.mem_write   = w_mem_write;
    assign ctrl_bus.pc_write    = w_pc_write;
    assign ctrl_bus.branch      = w_branch;
    assign ctrl_bus.reg_write   = w_reg_write;
    assign ctrl_bus.alu_src_b   = w_alu_src_b;
    assign ctrl_bus.pc_src      = w_pc_src;
    assign ctrl_bus.alu_control = ALU_CTRL_W'(w_alu);
    assign ctrl_bus.instr_done  = w_instr_done;
    assign ctrl_bus.illegal_op  = r_illegal_op;
    assign ctrl_bus.bus_err     = r_bus_err;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Directed bench for mc_ctrl_fsm. Outputs are packed into one 20-bit word:
//   [19] mem_req [18] mem_to_reg [17] reg_dest [16] i_or_d [15] alu_src_a
//   [14] ir_write [13] mem_write [12] pc_write [11] branch [10] reg_write
//   [9:8] alu_src_b [7:6] pc_src [5:3] alu_control [2] instr_done
//   [1] illegal_op [0] bus_err
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm_if #(.ALU_CTRL_W(3)) u_if ();

    mc_ctrl_fsm #(
        .ALU_CTRL_W  (3),
        .WAIT_TIMEOUT(16),
        .CNT_W       (5)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_bus(u_if)
    );

    localparam logic [19:0] E_ZERO      = 20'h0;
    localparam logic [19:0] E_FETCH_WT  = {10'b1000000000, 2'b01, 2'b00, 3'b010, 3'b000};
    localparam logic [19:0] E_FETCH_RDY = {10'b1000010100, 2'b01, 2'b00, 3'b010, 3'b000};
    localparam logic [19:0] E_DECODE    = {10'b0000000000, 2'b11, 2'b00, 3'b010, 3'b000};
    localparam logic [19:0] E_ALUWB     = {10'b0010000001, 2'b00, 2'b00, 3'b000, 3'b100};
    localparam logic [19:0] E_MEMADR    = {10'b0000100000, 2'b10, 2'b00, 3'b010, 3'b000};
    localparam logic [19:0] E_MEMRD     = {10'b1001000000, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [19:0] E_MEMWB     = {10'b0100000001, 2'b00, 2'b00, 3'b000, 3'b100};
    localparam logic [19:0] E_MEMWR     = {10'b1001001000, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [19:0] E_MEMWR_RDY = {10'b1001001000, 2'b00, 2'b00, 3'b000, 3'b100};
    localparam logic [19:0] E_BRANCH    = {10'b0000100010, 2'b00, 2'b01, 3'b110, 3'b100};
    localparam logic [19:0] E_JUMP      = {10'b0000000100, 2'b00, 2'b10, 3'b000, 3'b100};
    localparam logic [19:0] E_TRAP_ILL  = {10'b0000000000, 2'b00, 2'b00, 3'b000, 3'b010};
    localparam logic [19:0] E_TRAP_BUS  = {10'b0000000000, 2'b00, 2'b00, 3'b000, 3'b001};
`ifdef MC_ADDI_EN
    localparam logic [19:0] E_ADDIEX    = {10'b0000100000, 2'b10, 2'b00, 3'b010, 3'b000};
    localparam logic [19:0] E_ADDIWB    = {10'b0000000001, 2'b00, 2'b00, 3'b000, 3'b100};
`endif

    function automatic logic [19:0] pack_out();
        return {u_if.mem_req, u_if.mem_to_reg, u_if.reg_dest, u_if.i_or_d, u_if.alu_src_a,
                u_if.ir_write, u_if.mem_write, u_if.pc_write, u_if.branch, u_if.reg_write,
                u_if.alu_src_b, u_if.pc_src, u_if.alu_control, u_if.instr_done,
                u_if.illegal_op, u_if.bus_err};
    endfunction

    function automatic logic [19:0] exec_vec(input logic [2:0] alu);
        return {10'b0000100000, 2'b00, 2'b00, alu, 3'b000};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %05h want %05h", tag, obs, exp);
        end
    endtask

    // Compare the packed outputs after inputs have settled.
    task automatic chk(input string tag, input logic [19:0] exp);
        #1;
        check_eq(tag, {12'b0, pack_out()}, {12'b0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge; FETCH one edge after release.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        chk({tag, "_async"}, E_ZERO);
        @(negedge clk);
        rst = 1'b0;
        chk({tag, "_held"}, E_ZERO);
        tick();
    endtask

    // Fetch with mem_ready=1 then decode; leaves the FSM in the state after DECODE.
    task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
        opcode_set(op, fn);
        u_if.mem_ready = 1'b1;
        chk({tag, "_fetch"}, E_FETCH_RDY);
        tick();
        chk({tag, "_decode"}, E_DECODE);
        tick();
    endtask

    task automatic opcode_set(input logic [5:0] op, input logic [5:0] fn);
        u_if.opcode = op;
        u_if.funct  = fn;
    endtask

    logic [5:0] fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] alu_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    initial begin
        u_if.opcode    = 6'b0;
        u_if.funct     = 6'b0;
        u_if.mem_ready = 1'b1;

        do_reset("rst0");

        // R-type add, four cycles, retire on ALUWB
        fetch_decode("add", 6'b000000, 6'b100000);
        chk("add_exec", exec_vec(3'b010));
        tick();
        chk("add_aluwb", E_ALUWB);
        tick();

        // Fetch wait states, then every R-type funct
        for (int i = 0; i < 5; i++) begin
            opcode_set(6'b000000, fn_tab[i]);
            if (i == 1) begin
                u_if.mem_ready = 1'b0;
                chk("fetch_wait0", E_FETCH_WT);
                tick();
                chk("fetch_wait1", E_FETCH_WT);
                tick();
            end
            fetch_decode("rtype", 6'b000000, fn_tab[i]);
            chk($sformatf("rtype_exec%0d", i), exec_vec(alu_tab[i]));
            tick();
            chk($sformatf("rtype_wb%0d", i), E_ALUWB);
            tick();
        end

        // lw with three stall cycles in MEMRD
        fetch_decode("lw", 6'b100011, 6'b0);
        chk("lw_memadr", E_MEMADR);
        tick();
        u_if.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lw_memrd_stall%0d", i), E_MEMRD);
            tick();
        end
        u_if.mem_ready = 1'b1;
        chk("lw_memrd_done", E_MEMRD);
        tick();
        chk("lw_memwb", E_MEMWB);
        tick();
        chk("lw_back_fetch", E_FETCH_RDY);

        // sw completing on the last tolerated stall cycle: no trap
        fetch_decode("sw_edge", 6'b101011, 6'b0);
        chk("sw_edge_memadr", E_MEMADR);
        tick();
        u_if.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("sw_edge_c16", E_MEMWR);
        u_if.mem_ready = 1'b1;
        chk("sw_edge_done", E_MEMWR_RDY);
        tick();
        chk("sw_edge_fetch", E_FETCH_RDY);

        // branch and jump
        fetch_decode("beq", 6'b000100, 6'b0);
        chk("beq_branch", E_BRANCH);
        tick();
        fetch_decode("j", 6'b000010, 6'b0);
        chk("j_jump", E_JUMP);
        tick();

        // reset in the middle of a stalled store
        fetch_decode("sw_rst", 6'b101011, 6'b0);
        tick();
        u_if.mem_ready = 1'b0;
        chk("sw_rst_memwr", E_MEMWR);
        do_reset("rst_mid");
        u_if.mem_ready = 1'b1;
        chk("rst_mid_fetch", E_FETCH_RDY);

        // sw timeout: 16 stalled MEMWR cycles then bus trap
        fetch_decode("sw_tmo", 6'b101011, 6'b0);
        tick();
        u_if.mem_ready = 1'b0;
        chk("sw_tmo_c1", E_MEMWR);
        for (int i = 0; i < 15; i++) tick();
        chk("sw_tmo_c16", E_MEMWR);
        tick();
        chk("sw_tmo_trap", E_TRAP_BUS);
        u_if.mem_ready = 1'b1;
        tick();
        chk("sw_tmo_trap_hold", E_TRAP_BUS);
        do_reset("rst_bus");

        // illegal funct under opcode 0
        fetch_decode("badfn", 6'b000000, 6'b000000);
        chk("badfn_trap", E_TRAP_ILL);
        do_reset("rst_fn");

        // illegal opcode: flag sticky until reset
        fetch_decode("op3f", 6'b111111, 6'b0);
        chk("op3f_trap", E_TRAP_ILL);
        for (int i = 0; i < 3; i++) begin
            u_if.mem_ready = i[0];
            opcode_set(6'b000000, 6'b100000);
            tick();
            chk($sformatf("op3f_sticky%0d", i), E_TRAP_ILL);
        end
        do_reset("rst_ill");

        // addi: executes with the build option, traps without it
        fetch_decode("addi", 6'b001000, 6'b0);
`ifdef MC_ADDI_EN
        chk("addi_ex", E_ADDIEX);
        tick();
        chk("addi_wb", E_ADDIWB);
        tick();
        chk("addi_fetch", E_FETCH_RDY);
`else
        chk("addi_trap", E_TRAP_ILL);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
